// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - function-select encodings and sizing helpers for the register bank
package reg_bank_pkg;

  localparam logic [2:0] FS_DEC  = 3'b000;
  localparam logic [2:0] FS_INC  = 3'b001;
  localparam logic [2:0] FS_LOAD = 3'b010;
  localparam logic [2:0] FS_CLR  = 3'b011;
  localparam logic [2:0] FS_ZX8  = 3'b100;
  localparam logic [2:0] FS_ZX16 = 3'b101;
  localparam logic [2:0] FS_SHL8 = 3'b110;
  localparam logic [2:0] FS_SX16 = 3'b111;

  // Counter must hold the value WIDTH/8 itself, hence the extra bit.
  function automatic int byte_cnt_w(input int width);
    return $clog2(width / 8) + 1;
  endfunction

endpackage

// File: rtl/reg_cell.sv
// rtl/reg_cell.sv - one bank register with sticky overflow flag and byte-assembly counter
module reg_cell
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit SAT   = 1'b0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic             En,
  output logic [WIDTH-1:0] Q,
  output logic             Ovf,
  output logic             ByteFull
);

  localparam int            CW       = byte_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH / 8);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             q_zero, q_ones;

  assign q_zero = (q_q == '0);
  assign q_ones = (q_q == '1);

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (En) begin
      // Any selected operation other than SHL8 restarts byte assembly.
      cnt_d = '0;
      case (FunSel)
        FS_DEC: begin
          if (q_zero) begin
            ovf_d = 1'b1;
            if (SAT) q_d = '0;
            else     q_d = '1;
          end else begin
            q_d = q_q - WIDTH'(1);
          end
        end
        FS_INC: begin
          if (q_ones) begin
            ovf_d = 1'b1;
            if (SAT) q_d = '1;
            else     q_d = '0;
          end else begin
            q_d = q_q + WIDTH'(1);
          end
        end
        FS_LOAD: begin
          q_d   = I;
          ovf_d = 1'b0;
        end
        FS_CLR: begin
          q_d   = '0;
          ovf_d = 1'b0;
        end
        FS_ZX8:  q_d = {{(WIDTH-8){1'b0}}, I[7:0]};
        FS_ZX16: q_d = {{(WIDTH-16){1'b0}}, I[15:0]};
        FS_SHL8: begin
          q_d   = {q_q[WIDTH-9:0], I[7:0]};
          cnt_d = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CW'(1);
        end
        default: q_d = {{(WIDTH-16){I[15]}}, I[15:0]};
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      q_q   <= '0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
      cnt_q <= cnt_d;
    end
  end

  assign Q        = q_q;
  assign Ovf      = ovf_q;
  assign ByteFull = (cnt_q == CNT_FULL);

endmodule

// File: rtl/reg_bank_param.sv
// rtl/reg_bank_param.sv - NREG-entry register bank with shared function select and two read ports
module reg_bank_param
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREG  = 4,
  parameter bit SAT   = 1'b0
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [WIDTH-1:0]        I,
  input  logic [2:0]              FunSel,
  input  logic [NREG-1:0]         RegSel,
  input  logic [$clog2(NREG)-1:0] OutASel,
  input  logic [$clog2(NREG)-1:0] OutBSel,
  output logic [WIDTH-1:0]        OutA,
  output logic [WIDTH-1:0]        OutB,
  output logic [NREG-1:0]         Ovf,
  output logic [NREG-1:0]         ByteFull
);

  localparam int SELW = $clog2(NREG);

  logic [WIDTH-1:0] q_arr [NREG];

  for (genvar g = 0; g < NREG; g++) begin : g_cell
    reg_cell #(
      .WIDTH (WIDTH),
      .SAT   (SAT)
    ) u_cell (
      .Clock    (Clock),
      .Reset    (Reset),
      .I        (I),
      .FunSel   (FunSel),
      .En       (RegSel[g]),
      .Q        (q_arr[g]),
      .Ovf      (Ovf[g]),
      .ByteFull (ByteFull[g])
    );
  end

  // Read straight from stored state; indices beyond NREG match nothing and read 0.
  always_comb begin
    OutA = '0;
    OutB = '0;
    for (int k = 0; k < NREG; k++) begin
      if (OutASel == SELW'(k)) OutA = q_arr[k];
      if (OutBSel == SELW'(k)) OutB = q_arr[k];
    end
  end

endmodule

// File: tb/tb_reg_bank_param.sv
// tb/tb_reg_bank_param.sv - table-driven scoreboard bench for reg_bank_param (wrap and saturate builds)
module tb_reg_bank_param;
  import reg_bank_pkg::*;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  din = '0;
  logic [2:0]    fsel = 3'b000;
  logic [N-1:0]  rsel = '0;
  logic [SW-1:0] asel = '0, bsel = '0;
  logic [W-1:0]  a0, b0, a1, b1;
  logic [N-1:0]  ovf0, bf0, ovf1, bf1;

  int n_vec = 0;
  int n_err = 0;

  always #10 clk = ~clk;

  reg_bank_param #(.WIDTH(W), .NREG(N), .SAT(1'b0)) u_wrap (
    .Clock(clk), .Reset(rst_n), .I(din), .FunSel(fsel), .RegSel(rsel),
    .OutASel(asel), .OutBSel(bsel), .OutA(a0), .OutB(b0), .Ovf(ovf0), .ByteFull(bf0)
  );

  reg_bank_param #(.WIDTH(W), .NREG(N), .SAT(1'b1)) u_sat (
    .Clock(clk), .Reset(rst_n), .I(din), .FunSel(fsel), .RegSel(rsel),
    .OutASel(asel), .OutBSel(bsel), .OutA(a1), .OutB(b1), .Ovf(ovf1), .ByteFull(bf1)
  );

  typedef struct packed {
    logic [N-1:0][W-1:0] r;
    logic [N-1:0]        ovf;
    logic [N-1:0]        bf;
  } exp_t;

  typedef struct packed {
    logic         rst_n;
    logic [N-1:0] sel;
    logic [2:0]   fs;
    logic [W-1:0] din;
    exp_t         e;
  } vec_t;

  vec_t vecs [28];
  vec_t svecs [5];
  exp_t sb [$];

  function automatic vec_t mk(input logic rs, input logic [N-1:0] sel, input logic [2:0] fs,
                              input logic [W-1:0] d, input logic [W-1:0] r3, input logic [W-1:0] r2,
                              input logic [W-1:0] r1, input logic [W-1:0] r0,
                              input logic [N-1:0] ovf, input logic [N-1:0] bf);
    vec_t v;
    v.rst_n = rs; v.sel = sel; v.fs = fs; v.din = d;
    v.e.r   = {r3, r2, r1, r0};
    v.e.ovf = ovf; v.e.bf = bf;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_state(input int dut, input string tag, input exp_t e);
    for (int k = 0; k < N; k++) begin
      asel = SW'(k);
      bsel = SW'(N - 1 - k);
      #1;
      cmp($sformatf("%s OutA r%0d", tag, k), (dut != 0) ? a1 : a0, e.r[k]);
      cmp($sformatf("%s OutB r%0d", tag, N - 1 - k), (dut != 0) ? b1 : b0, e.r[N-1-k]);
    end
    cmp($sformatf("%s Ovf", tag), W'((dut != 0) ? ovf1 : ovf0), W'(e.ovf));
    cmp($sformatf("%s ByteFull", tag), W'((dut != 0) ? bf1 : bf0), W'(e.bf));
  endtask

  task automatic apply(input int dut, input string tag, input vec_t v);
    exp_t e;
    @(negedge clk);
    rst_n = v.rst_n; rsel = v.sel; fsel = v.fs; din = v.din;
    sb.push_back(v.e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s scoreboard: got empty queue expected 1 entry", tag);
    end else begin
      e = sb.pop_front();
      check_state(dut, tag, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = mk(0, 4'hF, FS_LOAD, 32'hFFFF_FFFF, 0, 0, 0, 0, 4'h0, 4'h0);
    vecs[1]  = mk(1, 4'hF, FS_LOAD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h0, 4'h0);
    vecs[2]  = mk(1, 4'hF, FS_CLR,  32'h0, 0, 0, 0, 0, 4'h0, 4'h0);
    vecs[3]  = mk(1, 4'h1, FS_DEC,  32'h0, 0, 0, 0, 32'hFFFF_FFFF, 4'h1, 4'h0);
    vecs[4]  = mk(1, 4'h1, FS_INC,  32'h0, 0, 0, 0, 0, 4'h1, 4'h0);
    vecs[5]  = mk(1, 4'h1, FS_LOAD, 32'h5, 0, 0, 0, 32'h5, 4'h0, 4'h0);
    vecs[6]  = mk(1, 4'h2, FS_CLR,  32'h0, 0, 0, 0, 32'h5, 4'h0, 4'h0);
    vecs[7]  = mk(1, 4'h2, FS_SHL8, 32'hFFFF_FF11, 0, 0, 32'h0000_0011, 32'h5, 4'h0, 4'h0);
    vecs[8]  = mk(1, 4'h2, FS_SHL8, 32'h0000_0022, 0, 0, 32'h0000_1122, 32'h5, 4'h0, 4'h0);
    vecs[9]  = mk(1, 4'h2, FS_SHL8, 32'h0000_0033, 0, 0, 32'h0011_2233, 32'h5, 4'h0, 4'h0);
    vecs[10] = mk(1, 4'h2, FS_SHL8, 32'h0000_0044, 0, 0, 32'h1122_3344, 32'h5, 4'h0, 4'h2);
    vecs[11] = mk(1, 4'h2, FS_SHL8, 32'h0000_0055, 0, 0, 32'h2233_4455, 32'h5, 4'h0, 4'h2);
    vecs[12] = mk(1, 4'h2, FS_INC,  32'h0, 0, 0, 32'h2233_4456, 32'h5, 4'h0, 4'h0);
    vecs[13] = mk(1, 4'h5, FS_SX16, 32'h0000_8001, 0, 32'hFFFF_8001, 32'h2233_4456, 32'hFFFF_8001, 4'h0, 4'h0);
    vecs[14] = mk(1, 4'h5, FS_SX16, 32'h1234_7FFF, 0, 32'h0000_7FFF, 32'h2233_4456, 32'h0000_7FFF, 4'h0, 4'h0);
    vecs[15] = mk(1, 4'h1, FS_ZX8,  32'hABCD_EF12, 0, 32'h0000_7FFF, 32'h2233_4456, 32'h0000_0012, 4'h0, 4'h0);
    vecs[16] = mk(1, 4'h8, FS_ZX16, 32'hABCD_EF12, 32'h0000_EF12, 32'h0000_7FFF, 32'h2233_4456, 32'h0000_0012, 4'h0, 4'h0);
    vecs[17] = mk(1, 4'h0, FS_LOAD, 32'hFFFF_FFFF, 32'h0000_EF12, 32'h0000_7FFF, 32'h2233_4456, 32'h0000_0012, 4'h0, 4'h0);
    vecs[18] = mk(1, 4'h2, FS_LOAD, 32'hFFFF_FFFF, 32'h0000_EF12, 32'h0000_7FFF, 32'hFFFF_FFFF, 32'h0000_0012, 4'h0, 4'h0);
    vecs[19] = mk(1, 4'h2, FS_INC,  32'h0, 32'h0000_EF12, 32'h0000_7FFF, 32'h0, 32'h0000_0012, 4'h2, 4'h0);
    vecs[20] = mk(1, 4'h1, FS_DEC,  32'h0, 32'h0000_EF12, 32'h0000_7FFF, 32'h0, 32'h0000_0011, 4'h2, 4'h0);
    vecs[21] = mk(1, 4'h8, FS_SHL8, 32'h0000_00AA, 32'h00EF_12AA, 32'h0000_7FFF, 32'h0, 32'h0000_0011, 4'h2, 4'h0);
    vecs[22] = mk(1, 4'h8, FS_SHL8, 32'h0000_00BB, 32'hEF12_AABB, 32'h0000_7FFF, 32'h0, 32'h0000_0011, 4'h2, 4'h0);
    vecs[23] = mk(0, 4'hF, FS_SHL8, 32'h0000_00CC, 0, 0, 0, 0, 4'h0, 4'h0);
    vecs[24] = mk(1, 4'h8, FS_SHL8, 32'h0000_0001, 32'h0000_0001, 0, 0, 0, 4'h0, 4'h0);
    vecs[25] = mk(1, 4'h8, FS_SHL8, 32'h0000_0002, 32'h0000_0102, 0, 0, 0, 4'h0, 4'h0);
    vecs[26] = mk(1, 4'h8, FS_SHL8, 32'h0000_0003, 32'h0001_0203, 0, 0, 0, 4'h0, 4'h0);
    vecs[27] = mk(1, 4'h8, FS_SHL8, 32'h0000_0004, 32'h0102_0304, 0, 0, 0, 4'h0, 4'h8);

    svecs[0] = mk(0, 4'hF, FS_LOAD, 32'hFFFF_FFFF, 0, 0, 0, 0, 4'h0, 4'h0);
    svecs[1] = mk(1, 4'h1, FS_DEC,  32'h0, 0, 0, 0, 0, 4'h1, 4'h0);
    svecs[2] = mk(1, 4'h1, FS_LOAD, 32'hFFFF_FFFF, 0, 0, 0, 32'hFFFF_FFFF, 4'h0, 4'h0);
    svecs[3] = mk(1, 4'h1, FS_INC,  32'h0, 0, 0, 0, 32'hFFFF_FFFF, 4'h1, 4'h0);
    svecs[4] = mk(1, 4'h1, FS_DEC,  32'h0, 0, 0, 0, 32'hFFFF_FFFE, 4'h1, 4'h0);

    for (int v = 0; v < 28; v++) apply(0, $sformatf("wrap v%0d", v), vecs[v]);

    // Same-index read ports: old contents until the edge, new contents after it.
    @(negedge clk);
    rst_n = 1'b1; rsel = 4'b0100; fsel = FS_LOAD; din = 32'hA5A5_A5A5;
    asel = 2'd2; bsel = 2'd2;
    #1;
    cmp("read old OutA", a0, 32'h0);
    cmp("read old OutB", b0, 32'h0);
    @(posedge clk);
    #1;
    cmp("read new OutA", a0, 32'hA5A5_A5A5);
    cmp("read new OutB", b0, 32'hA5A5_A5A5);

    for (int v = 0; v < 5; v++) apply(1, $sformatf("sat v%0d", v), svecs[v]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
